// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, PC
// next-value selection, and the fixed ARM PC offsets.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP          = 4;
    localparam int unsigned R15_OFFSET       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-value mux (hold, sequential step,
// redirect load). Exposes the next value so callers can latch it as an address.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  pc_sel_e           pc_sel_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel_i)
            PC_INC:  pc_d = pc_q + ADDR_W'(PC_STEP);
            PC_LOAD: pc_d = target_i;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding req/ack fetch into an
// instruction register, valid/ready to decode, redirects from execute.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus8,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instrPc_q, instrPc_d;
    logic              instrValid_q, instrValid_d;

    pc_sel_e           pcSel;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] targetAddr;
    logic              ackTaken;

    assign targetAddr = redirect_addr & ~ADDR_W'(3);
    assign ackTaken   = imem_ack && req_q;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc_sel_i  (pcSel),
        .target_i  (targetAddr),
        .pc_next_o (pcNext)
    );

    // A redirect always reloads the PC; the only sequential step is a consumed instruction.
    always_comb begin
        pcSel = PC_HOLD;
        if (redirect) begin
            pcSel = PC_LOAD;
        end else if (state_q == ST_HOLD && instr_ready) begin
            pcSel = PC_INC;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        instrPc_d    = instrPc_q;
        instrValid_d = instrValid_q;
        unique case (state_q)
            ST_IDLE: begin
                addr_d  = pcNext;
                req_d   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    // An in-flight request must keep its address, so it is drained in DROP.
                    if (ackTaken) begin
                        addr_d = pcNext;
                        req_d  = 1'b0;
                    end else if (req_q) begin
                        state_d = ST_DROP;
                    end else begin
                        addr_d = pcNext;
                        req_d  = 1'b1;
                    end
                end else if (ackTaken) begin
                    instr_d      = imem_rdata;
                    instrPc_d    = addr_q;
                    instrValid_d = 1'b1;
                    req_d        = 1'b0;
                    state_d      = ST_HOLD;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect || instr_ready) begin
                    instrValid_d = 1'b0;
                    addr_d       = pcNext;
                    req_d        = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (ackTaken) begin
                    addr_d  = pcNext;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            instr_q      <= 32'h0;
            instrPc_q    <= RESET_PC;
            instrValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            instrPc_q    <= instrPc_d;
            instrValid_q <= instrValid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = instrValid_q;
    assign instr       = instr_q;
    assign instr_pc    = instrPc_q;
    assign pc_plus8    = instrPc_q + ADDR_W'(R15_OFFSET);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic        redirect;
    logic [31:0] redirect_addr;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus8      (pc_plus8),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model view: either an instruction is held, a request is on the bus
    // (possibly doomed by a redirect), or nothing is in flight yet.
    logic [31:0] mPc, mAddr, mInstr, mIpc;
    bit          mReq, mValid, mDrop;

    always @(posedge clk or negedge reset_n) begin : modelBlk
        logic [31:0] tgt;
        if (!reset_n) begin
            mPc = 32'h0; mAddr = 32'h0; mInstr = 32'h0; mIpc = 32'h0;
            mReq = 1'b0; mValid = 1'b0; mDrop = 1'b0;
        end else begin
            tgt = {redirect_addr[31:2], 2'b00};
            if (mValid) begin
                if (redirect) begin
                    mPc = tgt; mValid = 1'b0; mAddr = mPc; mReq = 1'b1;
                end else if (instr_ready) begin
                    mPc = mIpc + 32'd4; mValid = 1'b0; mAddr = mPc; mReq = 1'b1;
                end
            end else if (mReq) begin
                if (redirect) mPc = tgt;
                if (imem_ack) begin
                    if (mDrop) begin
                        mAddr = mPc; mReq = 1'b1; mDrop = 1'b0;
                    end else if (redirect) begin
                        mAddr = mPc; mReq = 1'b0;
                    end else begin
                        mValid = 1'b1; mInstr = imem_rdata; mIpc = mAddr; mReq = 1'b0;
                    end
                end else if (redirect) begin
                    mDrop = 1'b1;
                end
            end else begin
                if (redirect) mPc = tgt;
                mAddr = mPc; mReq = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model imem_req",    32'(imem_req),    32'(mReq));
        checkOutput("model imem_addr",   imem_addr,        mAddr);
        checkOutput("model instr_valid", 32'(instr_valid), 32'(mValid));
        checkOutput("model instr",       instr,            mInstr);
        checkOutput("model instr_pc",    instr_pc,         mIpc);
        checkOutput("model pc_plus8",    pc_plus8,         mIpc + 32'd8);
    end

    task automatic applyStimulus(input bit ack, input bit rdy, input bit rd,
                                 input logic [31:0] ra, input logic [31:0] data);
        #1;
        imem_ack      = ack;
        instr_ready   = rdy;
        redirect      = rd;
        redirect_addr = ra;
        imem_rdata    = data;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        redirect_addr = 32'h0; imem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset imem_req",    32'(imem_req),    32'h0);
        checkOutput("reset imem_addr",   imem_addr,        32'h0);
        checkOutput("reset instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("reset instr",       instr,            32'h0);
        checkOutput("reset pc_plus8",    pc_plus8,         32'h8);

        $display("[TB] sequential fetch");
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("t1 req0",  32'(imem_req), 32'h1);
        checkOutput("t1 addr0", imem_addr,     32'h0);
        applyStimulus(1, 1, 0, 0, 32'hE3A0_0001);
        checkOutput("t1 valid0", 32'(instr_valid), 32'h1);
        checkOutput("t1 instr0", instr,            32'hE3A0_0001);
        checkOutput("t1 pc8_0",  pc_plus8,         32'h8);
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t1 addr4",  imem_addr,        32'h4);
        checkOutput("t1 gap",    32'(instr_valid), 32'h0);
        applyStimulus(1, 1, 0, 0, 32'hE3A0_0002);
        checkOutput("t1 pc8_1",  pc_plus8,         32'hC);
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t1 addr8",  imem_addr,        32'h8);
        applyStimulus(1, 0, 0, 0, 32'hE3A0_0003);
        checkOutput("t1 pc8_2",  pc_plus8,         32'h10);

        $display("[TB] decode stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 32'hDEAD_BEEF);
            checkOutput("t2 valid", 32'(instr_valid), 32'h1);
            checkOutput("t2 instr", instr,            32'hE3A0_0003);
            checkOutput("t2 pc",    instr_pc,         32'h8);
            checkOutput("t2 noreq", 32'(imem_req),    32'h0);
        end
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t2 addr12", imem_addr, 32'hC);

        $display("[TB] redirect during fetch");
        applyStimulus(0, 0, 1, 32'h100, 32'h0);
        checkOutput("t3 hold addr a", imem_addr, 32'hC);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("t3 hold addr b", imem_addr, 32'hC);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("t3 hold addr c", imem_addr, 32'hC);
        applyStimulus(1, 0, 0, 0, 32'hBAD0_BAD0);
        checkOutput("t3 dropped", 32'(instr_valid), 32'h0);
        checkOutput("t3 newaddr", imem_addr,        32'h100);
        applyStimulus(1, 0, 0, 0, 32'hE1A0_0000);
        checkOutput("t3 pc8", pc_plus8, 32'h108);

        $display("[TB] redirect in hold");
        applyStimulus(0, 1, 1, 32'h203, 32'h0);
        checkOutput("t4 addr",  imem_addr,        32'h200);
        checkOutput("t4 valid", 32'(instr_valid), 32'h0);
        applyStimulus(1, 0, 0, 0, 32'hE1A0_1111);
        checkOutput("t4 pc", instr_pc, 32'h200);

        $display("[TB] double redirect in drop");
        applyStimulus(0, 1, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h40, 32'h0);
        applyStimulus(0, 0, 1, 32'h80, 32'h0);
        checkOutput("t5 old addr", imem_addr, 32'h204);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("t5 addr", imem_addr, 32'h80);
        applyStimulus(1, 0, 0, 0, 32'hE1A0_2222);
        checkOutput("t5 pc", instr_pc, 32'h80);

        $display("[TB] async reset mid-fetch");
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t6 fetching", 32'(imem_req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6 req low",   32'(imem_req),    32'h0);
        checkOutput("t6 valid low", 32'(instr_valid), 32'h0);
        checkOutput("t6 addr rst",  imem_addr,        32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("t6 restart", imem_addr, 32'h0);

        $display("[TB] redirect with ack");
        applyStimulus(1, 0, 1, 32'h300, 32'h5555_5555);
        checkOutput("t8 bubble", 32'(imem_req),    32'h0);
        checkOutput("t8 addr",   imem_addr,        32'h300);
        checkOutput("t8 valid",  32'(instr_valid), 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("t8 req", 32'(imem_req), 32'h1);
        applyStimulus(1, 0, 0, 0, 32'hE1A0_3333);
        checkOutput("t8 pc", instr_pc, 32'h300);

        $display("[TB] address wrap");
        applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 32'h0);
        checkOutput("t7 addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 32'hE1A0_4444);
        checkOutput("t7 pc8", pc_plus8, 32'h4);
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t7 wrap", imem_addr, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : ($urandom & 32'h0000_0FFF);
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0, ra, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
